regfile_bist: RTL and testbench

REGFILE_BIST -- requirements
Module: regfile_bist

---
 rtl/regfile_pkg.sv | 27 ++
 rtl/regfile_bist_cmp.sv | 55 +++++
 rtl/regfile_bist.sv | 103 ++++++++++
 tb/tb_regfile_bist.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared constants, state type and pattern helper for the register-file BIST
package regfile_pkg;

    localparam int NUM_REGS = 32;
    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 64;
    localparam logic [ADDR_W-1:0] ZERO_REG = 5'd31;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        DONE  = 2'd3
    } bist_state_t;

    // Product is deliberately truncated to the data width before inversion.
    function automatic logic [DATA_W-1:0] pattern_word(
        input logic [ADDR_W-1:0] idx,
        input logic [DATA_W-1:0] pattern,
        input logic              inv
    );
        logic [DATA_W-1:0] prod;
        prod = {{(DATA_W-ADDR_W){1'b0}}, idx} * pattern;
        return prod ^ {DATA_W{inv}};
    endfunction

endpackage

// File: rtl/regfile_bist_cmp.sv
// rtl/regfile_bist_cmp.sv - dual-port read comparator with saturating error count and first-fail capture
module regfile_bist_cmp
    import regfile_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              en,
    input  logic [ADDR_W-1:0] idx,
    input  logic [DATA_W-1:0] expected,
    input  logic [DATA_W-1:0] ReadData1,
    input  logic [DATA_W-1:0] ReadData2,
    output logic [5:0]        error_count,
    output logic [ADDR_W-1:0] first_fail_reg
);

    logic [5:0]        error_count_q, error_count_d;
    logic [ADDR_W-1:0] first_fail_reg_q, first_fail_reg_d;
    logic              miss1, miss2;
    logic [1:0]        add;
    logic [6:0]        sum;

    always_comb begin
        miss1            = en && (ReadData1 != expected);
        miss2            = en && (ReadData2 != expected);
        add              = {1'b0, miss1} + {1'b0, miss2};
        sum              = {1'b0, error_count_q} + {5'b0, add};
        error_count_d    = error_count_q;
        first_fail_reg_d = first_fail_reg_q;
        if (clear) begin
            error_count_d    = 6'd0;
            first_fail_reg_d = '0;
        end else begin
            error_count_d = (sum > 7'd63) ? 6'd63 : sum[5:0];
            // The count never returns to zero within a run, so zero marks "no failure yet".
            if ((miss1 || miss2) && (error_count_q == 6'd0)) begin
                first_fail_reg_d = idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            error_count_q    <= 6'd0;
            first_fail_reg_q <= '0;
        end else begin
            error_count_q    <= error_count_d;
            first_fail_reg_q <= first_fail_reg_d;
        end
    end

    assign error_count    = error_count_q;
    assign first_fail_reg = first_fail_reg_q;

endmodule

// File: rtl/regfile_bist.sv
// rtl/regfile_bist.sv - write-all/read-all register-file self test sequencer
module regfile_bist
    import regfile_pkg::*;
#(
    parameter logic [63:0] PATTERN    = 64'h0000010204080001,
    parameter logic [63:0] ZERO_PROBE = 64'h00000000000000A0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        invert,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [5:0]  error_count,
    output logic [4:0]  first_fail_reg,
    output logic [4:0]  WriteRegister,
    output logic [4:0]  ReadRegister1,
    output logic [4:0]  ReadRegister2,
    output logic [63:0] WriteData,
    output logic        RegWrite,
    input  logic [63:0] ReadData1,
    input  logic [63:0] ReadData2
);

    bist_state_t       state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic              inv_q, inv_d;
    logic              cmp_clear, cmp_en;
    logic [DATA_W-1:0] expected;

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        inv_d         = inv_q;
        cmp_clear     = 1'b0;
        cmp_en        = 1'b0;
        expected      = '0;
        WriteRegister = '0;
        ReadRegister1 = '0;
        ReadRegister2 = '0;
        WriteData     = '0;
        RegWrite      = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d   = WRITE;
                    idx_d     = '0;
                    inv_d     = invert;
                    cmp_clear = 1'b1;
                end
            end
            WRITE: begin
                RegWrite      = 1'b1;
                WriteRegister = idx_q;
                WriteData     = (idx_q == ZERO_REG) ? ZERO_PROBE
                                                    : pattern_word(idx_q, PATTERN, inv_q);
                idx_d         = idx_q + 5'd1;
                if (idx_q == ZERO_REG) state_d = READ;
            end
            READ: begin
                ReadRegister1 = idx_q;
                ReadRegister2 = idx_q;
                cmp_en        = 1'b1;
                // Register 31 must read back zero regardless of the probe written to it.
                expected      = (idx_q == ZERO_REG) ? '0 : pattern_word(idx_q, PATTERN, inv_q);
                idx_d         = idx_q + 5'd1;
                if (idx_q == ZERO_REG) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            inv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            inv_q   <= inv_d;
        end
    end

    regfile_bist_cmp u_cmp (
        .clk            (clk),
        .reset          (reset),
        .clear          (cmp_clear),
        .en             (cmp_en),
        .idx            (idx_q),
        .expected       (expected),
        .ReadData1      (ReadData1),
        .ReadData2      (ReadData2),
        .error_count    (error_count),
        .first_fail_reg (first_fail_reg)
    );

    assign busy = (state_q == WRITE) || (state_q == READ);
    assign done = (state_q == DONE);
    assign pass = done && (error_count == 6'd0);

endmodule

// File: tb/tb_regfile_bist.sv
// tb/tb_regfile_bist.sv - directed self-checking bench for regfile_bist with a behavioural register file
module tb_regfile_bist;

    localparam logic [63:0] ZP = 64'h00000000000000A0;

    logic        clk = 1'b0;
    logic        reset, start, invert;
    logic        busy, done, pass, RegWrite;
    logic [5:0]  error_count;
    logic [4:0]  first_fail_reg, WriteRegister, ReadRegister1, ReadRegister2;
    logic [63:0] WriteData, ReadData1, ReadData2;

    logic [63:0] mem  [32];
    logic [63:0] wlog [32];
    logic        r31_writable, stuck3;
    int          n_checks, n_pass;
    int          bcnt;

    always #5 clk = ~clk;

    regfile_bist dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .invert         (invert),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .error_count    (error_count),
        .first_fail_reg (first_fail_reg),
        .WriteRegister  (WriteRegister),
        .ReadRegister1  (ReadRegister1),
        .ReadRegister2  (ReadRegister2),
        .WriteData      (WriteData),
        .RegWrite       (RegWrite),
        .ReadData1      (ReadData1),
        .ReadData2      (ReadData2)
    );

    function automatic logic [63:0] model_read(input logic [4:0] a, input logic [63:0] word,
                                               input logic wr31, input logic stk3);
        logic [63:0] r;
        r = (a == 5'd31 && !wr31) ? 64'd0 : word;
        if (stk3 && a == 5'd3) r[0] = 1'b0;
        return r;
    endfunction

    always @(posedge clk) begin
        if (RegWrite) begin
            if (WriteRegister != 5'd31 || r31_writable) mem[WriteRegister] <= WriteData;
            wlog[WriteRegister] <= WriteData;
        end
    end

    always_comb ReadData1 = model_read(ReadRegister1, mem[ReadRegister1], r31_writable, stuck3);
    always_comb ReadData2 = model_read(ReadRegister2, mem[ReadRegister2], r31_writable, stuck3);

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic wait_done(output int busy_n);
        int cyc;
        busy_n = 0;
        cyc    = 0;
        while (!done && cyc < 200) begin
            if (busy) busy_n++;
            cyc++;
            @(negedge clk);
        end
        check("done_timeout", 64'(done), 64'd1);
    endtask

    task automatic run(input logic inv, output int busy_n);
        @(negedge clk);
        start  = 1'b1;
        invert = inv;
        @(negedge clk);
        start  = 1'b0;
        invert = 1'b0;
        wait_done(busy_n);
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        r31_writable = 1'b0;
        stuck3 = 1'b0;
        for (int i = 0; i < 32; i++) begin
            mem[i]  = 64'd0;
            wlog[i] = 64'd0;
        end
        reset  = 1'b1;
        start  = 1'b0;
        invert = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_pass", 64'(pass), 64'd0);
        check("rst_err", 64'(error_count), 64'd0);
        check("rst_ffr", 64'(first_fail_reg), 64'd0);
        check("rst_regwrite", 64'(RegWrite), 64'd0);
        reset = 1'b0;

        // Clean run, no inversion
        run(1'b0, bcnt);
        check("t1_busy_cycles", 64'(bcnt), 64'd64);
        check("t1_pass", 64'(pass), 64'd1);
        check("t1_err", 64'(error_count), 64'd0);
        check("t1_wr_reg5", wlog[5], 64'h0000050A14280005);
        check("t1_wr_reg31", wlog[31], ZP);
        check("t1_done_busy", 64'(busy), 64'd0);
        check("t1_done_regwrite", 64'(RegWrite), 64'd0);
        check("t1_done_wdata", WriteData, 64'd0);
        check("t1_done_raddr", 64'(ReadRegister1), 64'd0);
        repeat (3) @(negedge clk);
        check("t1_done_hold", 64'(done), 64'd1);
        check("t1_pass_hold", 64'(pass), 64'd1);

        // Register 31 not hardwired to zero
        r31_writable = 1'b1;
        run(1'b0, bcnt);
        check("t2_err", 64'(error_count), 64'd2);
        check("t2_ffr", 64'(first_fail_reg), 64'd31);
        check("t2_pass", 64'(pass), 64'd0);
        r31_writable = 1'b0;

        // Bit 0 of register 3 stuck low
        stuck3 = 1'b1;
        run(1'b0, bcnt);
        check("t3_err", 64'(error_count), 64'd2);
        check("t3_ffr", 64'(first_fail_reg), 64'd3);
        check("t3_pass", 64'(pass), 64'd0);
        stuck3 = 1'b0;

        // Inverted patterns
        run(1'b1, bcnt);
        check("t4_wr_reg0", wlog[0], 64'hFFFFFFFFFFFFFFFF);
        check("t4_wr_reg5", wlog[5], 64'hFFFFFAF5EBD7FFFA);
        check("t4_wr_reg31", wlog[31], ZP);
        check("t4_err", 64'(error_count), 64'd0);
        check("t4_pass", 64'(pass), 64'd1);

        // Reset in the middle of the write phase
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        bcnt = 0;
        while (WriteRegister != 5'd10 && bcnt < 50) begin
            bcnt++;
            @(negedge clk);
        end
        check("t5_reached_idx10", 64'(WriteRegister), 64'd10);
        reset = 1'b1;
        @(negedge clk);
        check("t5_busy", 64'(busy), 64'd0);
        check("t5_regwrite", 64'(RegWrite), 64'd0);
        check("t5_waddr", 64'(WriteRegister), 64'd0);
        start = 1'b1;
        repeat (2) @(negedge clk);
        check("t5_start_in_reset", 64'(busy), 64'd0);
        reset = 1'b0;
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("t5_no_resume_busy", 64'(busy), 64'd0);
        check("t5_no_resume_done", 64'(done), 64'd0);

        // Start held high: no restart until DONE, then immediate rerun
        r31_writable = 1'b1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        wait_done(bcnt);
        check("t6_busy_cycles", 64'(bcnt), 64'd64);
        check("t6_err", 64'(error_count), 64'd2);
        r31_writable = 1'b0;
        @(negedge clk);
        check("t6_rerun_busy", 64'(busy), 64'd1);
        check("t6_rerun_done", 64'(done), 64'd0);
        check("t6_err_cleared", 64'(error_count), 64'd0);
        check("t6_ffr_cleared", 64'(first_fail_reg), 64'd0);
        start = 1'b0;
        wait_done(bcnt);
        check("t6_rerun_cycles", 64'(bcnt), 64'd64);
        check("t6_rerun_pass", 64'(pass), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
